// File: rtl/alu_decode_stage.sv
// ALU-control decode stage: maps op class / funct3 / funct7 to a registered ALU op and shift
// amount, with a valid/ready handshake and a divider-occupancy counter that stalls issue.
module alu_decode_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ENABLE_M   = 1,
    parameter int unsigned DIV_CYCLES = 32,
    localparam int unsigned SHAMT_W   = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op_class,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic [SHAMT_W-1:0] rs2_shamt,
    input  logic [SHAMT_W-1:0] imm_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         alu_op,
    output logic [SHAMT_W-1:0] shamt,
    output logic [2:0]         out_funct3,
    output logic               illegal,
    output logic               div_busy
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

    if (DIV_CYCLES < 1) begin : g_bad_div_cycles
        $error("DIV_CYCLES must be at least 1");
    end
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("XLEN must be 32 or 64");
    end

    typedef enum logic [4:0] {
        OpNop    = 5'b00000,
        OpAdd    = 5'b00001,
        OpSub    = 5'b00010,
        OpAnd    = 5'b00011,
        OpOr     = 5'b00100,
        OpXor    = 5'b00101,
        OpSll    = 5'b00110,
        OpSrl    = 5'b00111,
        OpSra    = 5'b01000,
        OpSlt    = 5'b01001,
        OpSltu   = 5'b01010,
        OpBranch = 5'b01111,
        OpMul    = 5'b10000,
        OpMulh   = 5'b10001,
        OpMulhsu = 5'b10010,
        OpMulhu  = 5'b10011,
        OpDiv    = 5'b10100,
        OpDivu   = 5'b10101,
        OpRem    = 5'b10110,
        OpRemu   = 5'b10111
    } alu_op_e;

    // Div-class ops occupy the 101xx corner of the encoding.
    function automatic logic is_div(input logic [4:0] op);
        return op[4:2] == 3'b101;
    endfunction

    alu_op_e              dec_op;
    logic [SHAMT_W-1:0]   dec_shamt;
    logic                 dec_ill;
    logic [6:0]           f7_imm;

    alu_op_e              alu_op_q;
    logic [SHAMT_W-1:0]   shamt_q;
    logic [2:0]           funct3_q;
    logic                 illegal_q;
    logic                 out_valid_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 accept;
    logic                 handoff;

    always_comb begin
        dec_op    = OpNop;
        dec_shamt = '0;
        dec_ill   = 1'b0;
        f7_imm    = funct7;
        // On RV64 funct7[0] carries shamt bit 5 for immediate shifts.
        if (XLEN == 64) begin
            f7_imm[0] = 1'b0;
        end
        unique case (op_class)
            2'b00: begin
                if (funct7 == 7'b0000000) begin
                    unique case (funct3)
                        3'b000: dec_op = OpAdd;
                        3'b001: begin
                            dec_op    = OpSll;
                            dec_shamt = rs2_shamt;
                        end
                        3'b010: dec_op = OpSlt;
                        3'b011: dec_op = OpSltu;
                        3'b100: dec_op = OpXor;
                        3'b101: begin
                            dec_op    = OpSrl;
                            dec_shamt = rs2_shamt;
                        end
                        3'b110: dec_op = OpOr;
                        default: dec_op = OpAnd;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_op = OpSub;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec_op    = OpSra;
                    dec_shamt = rs2_shamt;
                end else if (funct7 == 7'b0000001 && ENABLE_M != 0) begin
                    dec_op = alu_op_e'({2'b10, funct3});
                end else begin
                    dec_ill = 1'b1;
                end
            end
            2'b01: begin
                unique case (funct3)
                    3'b000: dec_op = OpAdd;
                    3'b001: begin
                        if (f7_imm == 7'b0000000) begin
                            dec_op    = OpSll;
                            dec_shamt = imm_shamt;
                        end else begin
                            dec_ill = 1'b1;
                        end
                    end
                    3'b010: dec_op = OpSlt;
                    3'b011: dec_op = OpSltu;
                    3'b100: dec_op = OpXor;
                    3'b101: begin
                        if (f7_imm == 7'b0000000) begin
                            dec_op    = OpSrl;
                            dec_shamt = imm_shamt;
                        end else if (f7_imm == 7'b0100000) begin
                            dec_op    = OpSra;
                            dec_shamt = imm_shamt;
                        end else begin
                            dec_ill = 1'b1;
                        end
                    end
                    3'b110: dec_op = OpOr;
                    default: dec_op = OpAnd;
                endcase
            end
            2'b10: dec_op = OpAdd;
            default: dec_op = OpBranch;
        endcase
    end

    assign div_busy = (cnt_q != '0);
    assign handoff  = out_valid_q & out_ready;
    // No accept on the edge a div op leaves: the counter is not yet loaded that cycle.
    assign in_ready = ~div_busy & ~(out_valid_q & is_div(alu_op_q)) & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            alu_op_q    <= OpNop;
            shamt_q     <= '0;
            funct3_q    <= 3'b000;
            illegal_q   <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            alu_op_q    <= dec_op;
            shamt_q     <= dec_shamt;
            funct3_q    <= funct3;
            illegal_q   <= dec_ill;
        end else if (handoff) begin
            out_valid_q <= 1'b0;
        end
    end

    // Flush does not touch the counter: a handed-off divide keeps the unit occupied.
    always_comb begin
        cnt_d = cnt_q;
        if (handoff && is_div(alu_op_q)) begin
            cnt_d = CNT_W'(DIV_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_op     = alu_op_q;
    assign shamt      = shamt_q;
    assign out_funct3 = funct3_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: instance A (RV32, M on, 4-cycle divide) and
// instance B (RV64, M off) with directed vectors and hand-computed expectations.
module tb_alu_decode_stage;

    typedef struct packed {
        logic [4:0] op;
        logic [5:0] sh;
        logic [2:0] f3;
        logic       ill;
    } exp_t;

    logic clk, rst_n;

    logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0] a_op_class;
    logic [2:0] a_funct3, a_out_funct3;
    logic [6:0] a_funct7;
    logic [4:0] a_rs2_shamt, a_imm_shamt, a_shamt, a_alu_op;
    logic       a_illegal, a_div_busy;

    logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [1:0] b_op_class;
    logic [2:0] b_funct3, b_out_funct3;
    logic [6:0] b_funct7;
    logic [5:0] b_rs2_shamt, b_imm_shamt, b_shamt;
    logic [4:0] b_alu_op;
    logic       b_illegal, b_div_busy;

    int applied = 0;
    int miscompares = 0;
    exp_t qa[$];
    exp_t qb[$];

    alu_decode_stage #(.XLEN(32), .ENABLE_M(1), .DIV_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .op_class(a_op_class), .funct3(a_funct3), .funct7(a_funct7),
        .rs2_shamt(a_rs2_shamt), .imm_shamt(a_imm_shamt), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .alu_op(a_alu_op), .shamt(a_shamt), .out_funct3(a_out_funct3),
        .illegal(a_illegal), .div_busy(a_div_busy)
    );

    alu_decode_stage #(.XLEN(64), .ENABLE_M(0), .DIV_CYCLES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .op_class(b_op_class), .funct3(b_funct3), .funct7(b_funct7),
        .rs2_shamt(b_rs2_shamt), .imm_shamt(b_imm_shamt), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .alu_op(b_alu_op), .shamt(b_shamt), .out_funct3(b_out_funct3),
        .illegal(b_illegal), .div_busy(b_div_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitors: pop the oldest expectation whenever a DUT hands off an op.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_output", 32'd1, 32'd0);
            end else begin
                e = qa.pop_front();
                chk("a_alu_op", 32'(a_alu_op), 32'(e.op));
                chk("a_shamt", 32'(a_shamt), 32'(e.sh));
                chk("a_funct3", 32'(a_out_funct3), 32'(e.f3));
                chk("a_illegal", 32'(a_illegal), 32'(e.ill));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_output", 32'd1, 32'd0);
            end else begin
                e = qb.pop_front();
                chk("b_alu_op", 32'(b_alu_op), 32'(e.op));
                chk("b_shamt", 32'(b_shamt), 32'(e.sh));
                chk("b_funct3", 32'(b_out_funct3), 32'(e.f3));
                chk("b_illegal", 32'(b_illegal), 32'(e.ill));
            end
        end
    end

    // Called at posedge+1; holds the beat until accepted, returns at posedge+1 after acceptance.
    task automatic send(input bit sb, input logic [1:0] cls, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [5:0] rs2, input logic [5:0] imm,
                        input logic [4:0] eop, input logic [5:0] esh, input logic eill,
                        output int waits, output int busy);
        logic rdy;
        exp_t e;
        waits = 0;
        busy  = 0;
        if (sb) begin
            b_in_valid = 1'b1; b_op_class = cls; b_funct3 = f3; b_funct7 = f7;
            b_rs2_shamt = rs2; b_imm_shamt = imm;
        end else begin
            a_in_valid = 1'b1; a_op_class = cls; a_funct3 = f3; a_funct7 = f7;
            a_rs2_shamt = rs2[4:0]; a_imm_shamt = imm[4:0];
        end
        busy += int'(sb ? b_div_busy : a_div_busy);
        rdy  = sb ? b_in_ready : a_in_ready;
        while (!rdy && waits < 40) begin
            @(posedge clk);
            #1;
            waits++;
            busy += int'(sb ? b_div_busy : a_div_busy);
            rdy  = sb ? b_in_ready : a_in_ready;
        end
        chk("accept_timeout", 32'(rdy), 32'd1);
        if (rdy) begin
            e = '{op: eop, sh: esh, f3: f3, ill: eill};
            if (sb) qb.push_back(e);
            else qa.push_back(e);
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, bz;
        a_flush = 0; a_in_valid = 0; a_out_ready = 1; a_op_class = 0; a_funct3 = 0;
        a_funct7 = 0; a_rs2_shamt = 0; a_imm_shamt = 0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 1; b_op_class = 0; b_funct3 = 0;
        b_funct7 = 0; b_rs2_shamt = 0; b_imm_shamt = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(a_out_valid), 0);
        chk("rst_alu_op", 32'(a_alu_op), 0);
        chk("rst_shamt", 32'(a_shamt), 0);
        chk("rst_funct3", 32'(a_out_funct3), 0);
        chk("rst_illegal", 32'(a_illegal), 0);
        chk("rst_div_busy", 32'(a_div_busy), 0);
        chk("rst_in_ready", 32'(a_in_ready), 1);
        chk("rst_b_in_ready", 32'(b_in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Instance A: RV32, M enabled, 4-cycle divide
        send(0, 2'b00, 3'b101, 7'b0100000, 6'd7, 6'd0, 5'b01000, 6'd7, 0, w, bz);
        send(0, 2'b00, 3'b000, 7'b0000000, 6'd3, 6'd0, 5'b00001, 6'd0, 0, w, bz);
        chk("b2b_add_wait", 32'(w), 0);
        send(0, 2'b00, 3'b100, 7'b0000000, 6'd9, 6'd0, 5'b00101, 6'd0, 0, w, bz);
        chk("b2b_xor_wait", 32'(w), 0);
        send(0, 2'b01, 3'b011, 7'b1010101, 6'd0, 6'd4, 5'b01010, 6'd0, 0, w, bz);
        chk("b2b_sltu_wait", 32'(w), 0);
        send(0, 2'b01, 3'b001, 7'b0000000, 6'd0, 6'd31, 5'b00110, 6'd31, 0, w, bz);
        send(0, 2'b01, 3'b101, 7'b0000001, 6'd0, 6'd33, 5'b00000, 6'd0, 1, w, bz);
        send(0, 2'b10, 3'b010, 7'b1111111, 6'd5, 6'd5, 5'b00001, 6'd0, 0, w, bz);
        send(0, 2'b11, 3'b110, 7'b0100000, 6'd5, 6'd5, 5'b01111, 6'd0, 0, w, bz);
        send(0, 2'b00, 3'b001, 7'b0100000, 6'd5, 6'd0, 5'b00000, 6'd0, 1, w, bz);
        send(0, 2'b00, 3'b001, 7'b0000000, 6'd12, 6'd0, 5'b00110, 6'd12, 0, w, bz);
        send(0, 2'b00, 3'b011, 7'b0000001, 6'd0, 6'd0, 5'b10011, 6'd0, 0, w, bz);
        send(0, 2'b00, 3'b100, 7'b0000001, 6'd0, 6'd0, 5'b10100, 6'd0, 0, w, bz);
        chk("div_no_stall_after_mulhu", 32'(w), 0);
        send(0, 2'b00, 3'b000, 7'b0000000, 6'd0, 6'd0, 5'b00001, 6'd0, 0, w, bz);
        chk("div_accept_waits", 32'(w), 5);
        chk("div_busy_cycles", 32'(bz), 4);

        // Flush with a held op and a coincident input beat
        @(posedge clk);
        #1;
        a_out_ready = 0;
        send(0, 2'b00, 3'b110, 7'b0000000, 6'd0, 6'd0, 5'b00100, 6'd0, 0, w, bz);
        chk("held_in_ready", 32'(a_in_ready), 0);
        a_in_valid = 1; a_op_class = 2'b00; a_funct3 = 3'b100; a_funct7 = 7'b0;
        a_flush = 1; a_out_ready = 1;
        @(posedge clk);
        #1;
        a_flush = 0; a_in_valid = 0;
        chk("flush_out_valid", 32'(a_out_valid), 0);
        chk("flush_illegal", 32'(a_illegal), 0);

        // Flush coincident with a div handoff, then reset mid-wait
        a_out_ready = 0;
        send(0, 2'b00, 3'b101, 7'b0000001, 6'd0, 6'd0, 5'b10101, 6'd0, 0, w, bz);
        a_flush = 1; a_out_ready = 1;
        @(posedge clk);
        #1;
        a_flush = 0;
        chk("flushdiv_out_valid", 32'(a_out_valid), 0);
        chk("flushdiv_busy", 32'(a_div_busy), 1);
        chk("flushdiv_in_ready", 32'(a_in_ready), 0);
        @(posedge clk);
        #1;
        chk("flushdiv_busy_later", 32'(a_div_busy), 1);
        rst_n = 0;
        #1;
        chk("midreset_busy", 32'(a_div_busy), 0);
        chk("midreset_in_ready", 32'(a_in_ready), 1);
        chk("midreset_out_valid", 32'(a_out_valid), 0);
        #2 rst_n = 1;
        @(posedge clk);
        #1;

        // Instance B: RV64, M disabled
        send(1, 2'b01, 3'b101, 7'b0000001, 6'd0, 6'd33, 5'b00111, 6'd33, 0, w, bz);
        send(1, 2'b01, 3'b101, 7'b0100001, 6'd0, 6'd40, 5'b01000, 6'd40, 0, w, bz);
        send(1, 2'b01, 3'b001, 7'b0000011, 6'd0, 6'd5, 5'b00000, 6'd0, 1, w, bz);
        send(1, 2'b00, 3'b000, 7'b0000001, 6'd0, 6'd0, 5'b00000, 6'd0, 1, w, bz);
        send(1, 2'b00, 3'b100, 7'b0000001, 6'd0, 6'd0, 5'b00000, 6'd0, 1, w, bz);
        chk("nom_div_wait", 32'(w), 0);
        send(1, 2'b00, 3'b101, 7'b0100000, 6'd63, 6'd0, 5'b01000, 6'd63, 0, w, bz);
        chk("nom_no_stall", 32'(w), 0);
        chk("nom_no_busy", 32'(bz), 0);
        @(posedge clk);
        #1;
        b_out_ready = 0;
        send(1, 2'b10, 3'b010, 7'b0000000, 6'd0, 6'd0, 5'b00001, 6'd0, 0, w, bz);
        for (int i = 0; i < 3; i++) begin
            chk("hold_out_valid", 32'(b_out_valid), 1);
            chk("hold_alu_op", 32'(b_alu_op), 1);
            chk("hold_funct3", 32'(b_out_funct3), 2);
            chk("hold_in_ready", 32'(b_in_ready), 0);
            @(posedge clk);
            #1;
        end
        b_out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("qa_drained", 32'(qa.size()), 0);
        chk("qb_drained", 32'(qb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
